// File: rtl/rmw_masked_writer.sv
// rmw_masked_writer: initiator side of a byte-masked write port.
// Each accepted request becomes a read-modify-write on an external memory that
// has a combinational read port and a registered write port.
// Optional feature macro: RMW_FULLMASK_SKIP_EN. When defined, a request whose
// mask is all ones goes straight from IDLE to WRITE, because nothing needs to
// be preserved from the old word.
// DATA_W must be a multiple of 8; MASK_W is derived from it.
`timescale 1ns/1ps

module rmw_masked_writer #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [MASK_W-1:0] req_mask,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [MASK_W-1:0]   mask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                busy_q;
  logic                wen_q;
  logic                done_q;
  logic [DATA_W-1:0]   byte_mask;

  // Expand each byte enable into eight bit enables for the merge.
  always_comb begin
    byte_mask = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      byte_mask[8*i +: 8] = {8{mask_q[i]}};
    end
  end

  // Request FSM; all handshake/status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && ready_q) begin
            addr_q  <= req_addr;
            data_q  <= req_data;
            mask_q  <= req_mask;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef RMW_FULLMASK_SKIP_EN
            if (&req_mask) begin
              // Full overwrite: the old word is irrelevant, go straight to WRITE.
              state_q <= StWrite;
              wen_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRead;
            end
`else
            state_q <= StRead;
`endif
          end
        end
        StRead: begin
          rdata_q <= mem_rdata;
          state_q <= StWrite;
          wen_q   <= |mask_q;
          done_q  <= 1'b1;
        end
        StWrite: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Addresses come straight from addr_q so they never glitch between states.
  always_comb begin
    req_ready = ready_q;
    busy      = busy_q;
    mem_wen   = wen_q;
    done      = done_q;
    mem_raddr = addr_q;
    mem_waddr = addr_q;
    // With a full mask rdata_q is fully masked off, so the skip path needs no read.
    mem_wdata = (data_q & byte_mask) | (rdata_q & ~byte_mask);
  end

endmodule

// File: tb/tb_rmw_masked_writer.sv
// Self-checking bench for rmw_masked_writer: an environment memory, a
// transaction-level reference model, per-cycle comparison and directed cases.
`timescale 1ns/1ps

module tb_rmw_masked_writer;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int MW = 4;
`ifdef RMW_FULLMASK_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [MW-1:0] req_mask = '0;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          done;
  logic          busy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rmw_masked_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .busy      (busy)
  );

  // Environment memory: combinational read, registered write, plus a preload port.
  logic [DW-1:0] mem_arr [8];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign mem_rdata = mem_arr[mem_raddr];

  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (mem_wen) mem_arr[mem_waddr] <= mem_wdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] nw, input logic [DW-1:0] old,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < MW; i++) r[8*i +: 8] = m[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Reference model: one outstanding request, retired lat edges after acceptance.
  logic [DW-1:0] ref_mem [8];
  int            e = 0;
  int            acc_e = 0;
  int            lat = 2;
  bit            pend = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [MW-1:0] m_mask = '0;

  always @(posedge clk) begin
    e = e + 1;
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (!reset) begin
      pend   = 1'b0;
      m_addr = '0;
    end else if (pend) begin
      if (e == acc_e + lat) begin
        if (m_mask != '0) ref_mem[m_addr] = merge(m_data, ref_mem[m_addr], m_mask);
        pend = 1'b0;
      end
    end else if (req_valid) begin
      pend   = 1'b1;
      acc_e  = e;
      m_addr = req_addr;
      m_data = req_data;
      m_mask = req_mask;
      lat    = (SKIP && (req_mask == 4'hF)) ? 1 : 2;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_done;
      exp_done = pend && (e == acc_e + lat - 1);
      check("ready", 32'(req_ready), 32'(!pend));
      check("busy", 32'(busy), 32'(pend));
      check("done", 32'(done), 32'(exp_done));
      check("wen", 32'(mem_wen), 32'(exp_done && (m_mask != '0)));
      check("raddr", 32'(mem_raddr), 32'(m_addr));
      check("waddr", 32'(mem_waddr), 32'(m_addr));
      if (exp_done && (m_mask != '0))
        check("wdata", mem_wdata, merge(m_data, ref_mem[m_addr], m_mask));
      if (done) done_cnt++;
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present a request and return right after the edge that accepts it; valid stays high.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_mask = m;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  // Count negedges from acceptance until done is seen; 99 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) n = 99;
  endtask

  int n;
  int base;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    for (int i = 0; i < 8; i++) preload(AW'(i), 32'h0);

    // 1: partial mask merge
    preload(3'd5, 32'h11223344);
    send(3'd5, 32'hAABBCCDD, 4'b0101);
    wait_done(n);
    check("t1_lat", 32'(n), 32'd1);
    check("t1_wen", 32'(mem_wen), 32'd1);
    check("t1_wdata", mem_wdata, 32'h11BB33DD);
    @(negedge clk);
    check("t1_mem", mem_arr[5], 32'h11BB33DD);

    // 2: zero mask leaves memory alone but still retires
    preload(3'd2, 32'h0BADBEEF);
    send(3'd2, 32'hFFFFFFFF, 4'b0000);
    wait_done(n);
    check("t2_lat", 32'(n), 32'd1);
    check("t2_wen", 32'(mem_wen), 32'd0);
    repeat (2) @(negedge clk);
    check("t2_mem", mem_arr[2], 32'h0BADBEEF);

    // 3: back-to-back with valid held high; order matters at address 1
    base = done_cnt;
    send(3'd1, 32'h01020304, 4'b1111);
    send(3'd1, 32'hA0B0C0D0, 4'b0001);
    send(3'd3, 32'h55667788, 4'b0110);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_dones", 32'(done_cnt - base), 32'd3);
    check("t3_mem1", mem_arr[1], 32'h010203D0);
    check("t3_mem3", mem_arr[3], 32'h00667700);

    // 4: full mask, latency depends on the skip option
    send(3'd7, 32'hDEADBEEF, 4'hF);
    wait_done(n);
    check("t4_lat", 32'(n), SKIP ? 32'd0 : 32'd1);
    @(negedge clk);
    check("t4_mem", mem_arr[7], 32'hDEADBEEF);

    // 5: reset during READ drops the request
    preload(3'd4, 32'hCAFEF00D);
    base = done_cnt;
    send(3'd4, 32'h00000000, 4'b0011);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t5_ready", 32'(req_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_wen", 32'(mem_wen), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_dones", 32'(done_cnt - base), 32'd0);
    check("t5_mem", mem_arr[4], 32'hCAFEF00D);

    // 6: top byte only, at both address extremes
    preload(3'd0, 32'h12345678);
    preload(3'd7, 32'h9ABCDEF0);
    send(3'd0, 32'hEE000000, 4'b1000);
    wait_done(n);
    send(3'd7, 32'h77FFFFFF, 4'b1000);
    wait_done(n);
    @(negedge clk);
    check("t6_mem0", mem_arr[0], 32'hEE345678);
    check("t6_mem7", mem_arr[7], 32'h77BCDEF0);

    // Randomised traffic with occasional resets while idle or in READ.
    for (int i = 0; i < 8; i++) preload(AW'(i), $urandom);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ((!pend || (lat == 2 && e == acc_e)) && ($urandom_range(0, 29) == 0)) reset = 1'b0;
      else reset = 1'b1;
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = AW'($urandom);
      req_data  = $urandom;
      case ($urandom_range(0, 5))
        0: req_mask = 4'hF;
        1: req_mask = 4'h0;
        default: req_mask = MW'($urandom);
      endcase
    end
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("final_mem%0d", i), mem_arr[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
